// File: rtl/pipe_pkg.sv
// Shared types for elastic (valid/ready) pipeline stages.
package pipe_pkg;

    typedef enum logic [1:0] {
        PS_EMPTY,
        PS_FULL,
        PS_SKID
    } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: main + skid entry so in_ready can be a flop
// while still sustaining one payload per cycle.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t      state, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             in_ready_q;

    always_comb begin
        state_n = state;
        main_n  = main_q;
        skid_n  = skid_q;
        if (flush) begin
            state_n = PS_EMPTY;
            main_n  = RESET_VAL;
            skid_n  = RESET_VAL;
        end else begin
            case (state)
                PS_EMPTY: begin
                    if (in_valid) begin
                        main_n  = in_data;
                        state_n = PS_FULL;
                    end
                end
                PS_FULL: begin
                    if (out_ready) begin
                        if (in_valid) begin
                            main_n = in_data;
                        end else begin
                            state_n = PS_EMPTY;
                        end
                    end else if (in_valid) begin
                        // in_ready was already high this cycle, so park the beat
                        skid_n  = in_data;
                        state_n = PS_SKID;
                    end
                end
                PS_SKID: begin
                    if (out_ready) begin
                        main_n  = skid_q;
                        state_n = PS_FULL;
                    end
                end
                default: state_n = PS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PS_EMPTY;
            main_q     <= RESET_VAL;
            skid_q     <= RESET_VAL;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_n;
            main_q     <= main_n;
            skid_q     <= skid_n;
            in_ready_q <= (state_n != PS_SKID);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state != PS_EMPTY);
    assign out_data  = main_q;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (out_valid & ~out_ready),
        .q     (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: queue-of-payloads reference model.
module tb_pipe_skid_reg;

    localparam int               WIDTH     = 32;
    localparam int               CNT_W     = 4;
    localparam logic [WIDTH-1:0] RESET_VAL = 32'h5A5A_0000;
    localparam int               CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] stall_cnt;

    pipe_skid_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int               n_chk  = 0;
    int               n_pass = 0;
    logic [WIDTH-1:0] q[$];
    logic             acc_this = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // One cycle of stimulus; accepted beats become expected outputs.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic ordy,
                       input logic fl, input logic clr);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
        @(negedge clk);
        acc_this = !reset && in_valid && in_ready && !flush;
        if (acc_this) q.push_back(in_data);
    endtask

    // Monitor: occupancy, ordering, stability and stall-count model.
    int               exp_cnt   = 0;
    logic             stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;

    always begin
        int occ;
        @(negedge clk);
        #1;
        if (reset) begin
            q.delete();
            exp_cnt    = 0;
            stall_prev = 1'b0;
        end else begin
            occ = q.size() - (acc_this ? 1 : 0);
            check("out_valid", 64'(out_valid), 64'(occ > 0));
            check("in_ready", 64'(in_ready), 64'(occ < 2));
            check("stall_cnt", 64'(stall_cnt), 64'(exp_cnt));
            if (occ > 0 && out_valid) check("out_data", 64'(out_data), 64'(q[0]));
            if (stall_prev) check("stable_under_stall", 64'(out_data), 64'(prev_data));
            if (out_valid && out_ready && occ > 0) void'(q.pop_front());
            if (flush) q.delete();
            if (cnt_clr) exp_cnt = 0;
            else if (occ > 0 && !out_ready && exp_cnt < CNT_MAX) exp_cnt++;
            stall_prev = out_valid && !out_ready && !flush;
            prev_data  = out_data;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 1000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        check("reset_in_ready", 64'(in_ready), 64'(1));
        check("reset_out_data", 64'(out_data), 64'(RESET_VAL));

        // streaming 1..8 with out_ready held high
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
            check("stream_in_ready", 64'(in_ready), 64'(1));
        end
        repeat (2) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // backpressure: A in main, B into skid, then release
        cyc(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("skid_in_ready", 64'(in_ready), 64'(0));
        check("skid_head", 64'(out_data), 64'(32'hA));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_second", 64'(out_data), 64'(32'hB));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("drain_in_ready", 64'(in_ready), 64'(1));

        // flush while in SKID with a beat offered
        cyc(1'b1, 32'h1A, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1B, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready", 64'(in_ready), 64'(1));
        check("flush_out_data", 64'(out_data), 64'(RESET_VAL));

        // stall counter saturation and clear
        cyc(1'b1, 32'hD, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("stall_sat", 64'(stall_cnt), 64'(CNT_MAX));
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("stall_clr", 64'(stall_cnt), 64'(0));

        // asynchronous reset mid-stream
        cyc(1'b1, 32'hE, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        acc_this = 1'b0;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'(0));
        check("arst_out_data", 64'(out_data), 64'(RESET_VAL));
        check("arst_in_ready", 64'(in_ready), 64'(1));
        check("arst_stall_cnt", 64'(stall_cnt), 64'(0));
        @(posedge clk);
        #1 reset = 1'b0;

        // randomized valid/ready/flush/clear traffic
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 63) == 0, $urandom_range(0, 31) == 0);
        end

        repeat (4) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("final_queue_empty", 64'(q.size()), 64'(0));
        check("final_out_valid", 64'(out_valid), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
